// File: rtl/pipe_adder.sv
// Pipelined N-bit add/subtract with valid/ready handshake; the carry chain is cut
// into W-bit chunks, one per stage. Define PIPE_ADDER_SAT_EN for signed saturation.
module pipe_adder #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int STAGES = N / W;

  logic en;

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    // b_i carries only the chunks of b' not yet consumed, so it shrinks by W per stage.
    localparam int BW = N - k * W;

    logic [N-1:0]  x_i;   // lower chunks: result so far, upper chunks: operand a
    logic [BW-1:0] b_i;
    logic          c_i;
    logic          v_i;
    logic          sub_i;
    logic [W:0]    add;
    logic [N-1:0]  x_o;

    if (k == 0) begin : head
      assign x_i   = a;
      assign b_i   = sub ? ~b : b;
      assign c_i   = sub ? ~cin : cin;
      assign v_i   = in_valid;
      assign sub_i = sub;
    end else begin : link
      assign x_i   = stg[k-1].body.x_q;
      assign b_i   = stg[k-1].body.b_q;
      assign c_i   = stg[k-1].body.c_q;
      assign v_i   = stg[k-1].body.v_q;
      assign sub_i = stg[k-1].body.sub_q;
    end

    assign add = {1'b0, x_i[k*W +: W]} + {1'b0, b_i[W-1:0]} + {{W{1'b0}}, c_i};

    // NOTE: default the whole word first so the partial chunk write cannot infer a latch.
    always_comb begin
      x_o             = x_i;
      x_o[k*W +: W]   = add[W-1:0];
    end

    if (k < STAGES - 1) begin : body
      logic [N-1:0]    x_q;
      logic [BW-W-1:0] b_q;
      logic            c_q;
      logic            v_q;
      logic            sub_q;

      // NOTE: only the valid bit is reset; datapath flops are qualified by it, so
      // leaving them unreset is safe and keeps the reset tree small.
      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= 1'b0;
        end else if (en) begin
          v_q   <= v_i;
          x_q   <= x_o;
          b_q   <= b_i[BW-1:W];
          c_q   <= add[W];
          sub_q <= sub_i;
        end
      end
    end else begin : tail
      logic         c_msb;
      logic         ovf_n;
      logic [N-1:0] sum_n;

      // Carry into the MSB recovered from the MSB sum bit and its two addend bits.
      assign c_msb = x_o[N-1] ^ x_i[N-1] ^ b_i[W-1];
      assign ovf_n = c_msb ^ add[W];

`ifdef PIPE_ADDER_SAT_EN
      assign sum_n = ovf_n ? {x_i[N-1], {(N-1){~x_i[N-1]}}} : x_o;
`else
      assign sum_n = x_o;
`endif

      // NOTE: sequential state uses non-blocking assignments so all stages update together.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid <= 1'b0;
          sum       <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
        end else if (en) begin
          out_valid <= v_i;
          sum       <= sum_n;
          cout      <= add[W] ^ sub_i;
          ovf       <= ovf_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder (N=16, W=4): directed corner cases, latency,
// streaming under toggling backpressure with a mid-stream reset, then random traffic.
module tb_pipe_adder;

  localparam int N      = 16;
  localparam int W      = 4;
  localparam int STAGES = N / W;

  typedef struct packed {
    logic [N-1:0] s;
    logic         c;
    logic         o;
  } res_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;

  int   total = 0;
  int   bad   = 0;
  res_t q[$];

  pipe_adder #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural operation.
  function automatic res_t model(input logic [N-1:0] x, input logic [N-1:0] y,
                                 input logic ci, input logic su);
    res_t t;
    int   r;
    int   sr;
    int   sx;
    int   sy;
    sx = $signed(x);
    sy = $signed(y);
    if (!su) begin
      r   = int'(x) + int'(y) + int'(ci);
      sr  = sx + sy + int'(ci);
      t.c = (r > 65535);
    end else begin
      r   = int'(x) - int'(y) - int'(ci);
      sr  = sx - sy - int'(ci);
      t.c = (r < 0);
    end
    t.s = r[N-1:0];
    t.o = (sr > 32767) || (sr < -32768);
`ifdef PIPE_ADDER_SAT_EN
    if (t.o) t.s = x[N-1] ? 16'h8000 : 16'h7FFF;
`endif
    return t;
  endfunction

  // Monitor: pops and compares on every retirement, checks in_ready and stall hold.
  initial begin
    logic         prev_stall;
    logic [N+2:0] held;
    res_t         e;
    prev_stall = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        check("in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
        if (prev_stall)
          check("stall_hold", {29'd0, out_valid, sum, cout, ovf}, {29'd0, held});
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            check("unexpected_out", {16'd0, sum}, 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            check("sum",  {16'd0, sum},  {16'd0, e.s});
            check("cout", {31'd0, cout}, {31'd0, e.c});
            check("ovf",  {31'd0, ovf},  {31'd0, e.o});
          end
        end
        prev_stall = out_valid && !out_ready;
        held       = {out_valid, sum, cout, ovf};
      end
    end
  end

  // One isolated operation with out_ready high; also measures latency in edges.
  task automatic single_op(input logic [N-1:0] x, input logic [N-1:0] y,
                           input logic ci, input logic su);
    int lat;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = x; b = y; cin = ci; sub = su;
    @(negedge clk);
    if (in_ready) q.push_back(model(x, y, ci, su));
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
    check("latency", lat, STAGES);
  endtask

  task automatic stream(input int nops, input int rst_at, input bit toggle);
    int           sent;
    int           cyc;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic         rc;
    logic         rs;
    sent = 0;
    cyc  = 0;
    ra = N'($urandom); rb = N'($urandom); rc = 1'($urandom); rs = 1'($urandom);
    while (sent < nops && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      out_ready = toggle ? ~out_ready : 1'($urandom_range(0, 1));
      if (cyc == rst_at) begin
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        check("rst_flush_valid", {31'd0, out_valid}, 32'd0);
        continue;
      end
      in_valid = toggle ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      a = ra; b = rb; cin = rc; sub = rs;
      @(negedge clk);
      if (in_valid && in_ready) begin
        q.push_back(model(ra, rb, rc, rs));
        sent++;
        ra = N'($urandom); rb = N'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      end
    end
    check("stream_budget", {31'd0, sent >= nops}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (STAGES + 2) @(negedge clk);
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum",       {16'd0, sum},       32'd0);
    check("rst_cout",      {31'd0, cout},      32'd0);
    check("rst_ovf",       {31'd0, ovf},       32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);

    single_op(16'h0001, 16'h0001, 1'b0, 1'b0);
    single_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    single_op(16'h0003, 16'h0007, 1'b0, 1'b1);
    single_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    single_op(16'h8000, 16'h0001, 1'b0, 1'b1);
    single_op(16'h8000, 16'h8000, 1'b0, 1'b0);
    drain();

    out_ready = 1'b1;
    stream(8, 7, 1'b1);
    drain();

    stream(40, 0, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
    $fatal(1, "watchdog");
  end

endmodule
